rr_grant_arbiter16: RTL
=======================

Name: rr_grant_arbiter16

Overview:
- Round-robin arbiter that shares one downstream resource among 16 requesters.
- Produces a registered one-hot grant plus its 4-bit binary index. The index uses the same one-hot-to-binary mapping as the team's 16-to-4 encoder.
- Grant is held until the owner releases it. Sits between requesting agents and the shared resource/encoder path.

Parameters:
- NUM_REQ, 16, number of requesters; fixed at 16 in this revision.
- IDX_W, 4, width of grant index, log2(NUM_REQ).
- MAX_HOLD, 255, watchdog limit in cycles; used only when the optional feature is compiled in.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  arbitration enable; low blocks new grants only.
- req  input  16  request vector; bit i is requester i.
- done  input  1  release strobe from the current owner.
- grant  output  16  registered one-hot grant; all-zero when idle.
- grant_idx  output  4  binary index of grant; 0 when idle.
- grant_valid  output  1  high while any grant is held.
- timeout  output  1  one-cycle pulse on a forced release; tied 0 without the optional feature.

Behaviour:
- Reset (async, rst_n=0):
  - grant=0, grant_idx=0, grant_valid=0, timeout=0.
  - Priority pointer ptr=0; state=IDLE. Takes effect immediately, including mid-grant.
- State IDLE:
  - If enable=1 and req!=0 at edge N: pick the first set req bit searching circularly from ptr upward (ptr, ptr+1, ... wrapping 15->0).
  - grant, grant_idx and grant_valid are registered at edge N; state becomes GRANT. Latency is one cycle from req to grant.
  - If enable=0 or req=0: stay IDLE, outputs zero.
- State GRANT, with owner k:
  - Grant is held unchanged; enable=0 does not preempt.
  - Release occurs when done=1, or when req[k]=0.
  - On release at edge M: grant=0, grant_valid=0, grant_idx=0, ptr=(k+1) mod 16, state=IDLE.
  - The earliest next grant is therefore edge M+1. A one-cycle gap between owners is guaranteed.
- done while IDLE: ignored.
- Requests from non-owners during GRANT: ignored; they are evaluated at the next IDLE cycle.
- done=1 and req[k] still high at the same edge: release wins. k is last in priority for the next pick.
- ptr wrap: ptr=15 owner releases -> ptr=0.
- Outputs are driven from flops only; there are no combinational paths from inputs to outputs.
- Invariants:
  - grant is always zero or one-hot.
  - grant_valid == (grant!=0).
  - grant_idx encodes grant.

Optional Feature:
- Macro: RR_GRANT_WATCHDOG_EN.
- Defined:
  - An 8-bit hold counter clears on each new grant and increments each GRANT cycle.
  - When it reaches MAX_HOLD with no release, the grant is forced off and ptr=(k+1) mod 16. timeout pulses high for that one cycle; state=IDLE.
  - A normal release on the same edge takes precedence; timeout stays 0.
- Undefined: no counter; timeout tied 0; grants are held indefinitely.

Decomposition:
- Shared package rr_grant_pkg:
  - NUM_REQ and IDX_W constants.
  - State enum {IDLE, GRANT}.
  - Default MAX_HOLD constant.
- Sub-module rr_pick16 (combinational):
  - Inputs: req[15:0], ptr[3:0].
  - Outputs: one-hot pick[15:0], pick_idx[3:0], any.
  - Implemented as rotate, fixed-priority select, rotate back.
- The top level holds the FSM, ptr, output registers and watchdog.

Test Plan:
- Reset then req=16'h0001, enable=1 -> next edge: grant=16'h0001, grant_idx=0, grant_valid=1. done pulse -> grant=0 next edge; ptr=1.
- ptr=0, req=16'h8004 simultaneously -> grant_idx=2. After release with both still requesting -> grant_idx=15, one idle cycle between grants. Then release 15 -> ptr wraps to 0.
- Owner k=5 held; enable dropped to 0 -> grant stays 16'h0020. After done -> no new grant while enable=0, despite req=16'hFFFF.
- req=16'hFFFF held, done pulsed at each grant -> grant_idx sequence 0,1,2,...,15,0 with one idle cycle each. Fairness: no index repeats before all 16 are served.
- rst_n asserted low mid-grant (owner 9), asynchronously between edges -> grant=0, grant_valid=0 immediately. After release of reset with req=16'h0200 -> grant_idx=9 from ptr=0.
- With RR_GRANT_WATCHDOG_EN, MAX_HOLD=4: owner 3 never releases -> forced off after 4 GRANT cycles, timeout=1 for one cycle. Next grant goes to requester 4 if it is requesting.

Source files
------------

// File: rtl/rr_grant_pkg.sv
// Shared constants and FSM state type for the 16-way round-robin grant arbiter.
package rr_grant_pkg;

  localparam int NUM_REQ          = 16;
  localparam int IDX_W            = 4;
  localparam int MAX_HOLD_DEFAULT = 255;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin pick: rotate req so ptr sits at bit 0, take the lowest set bit,
// rotate the one-hot result back. Zero latency; no flow control of its own.
module rr_pick16
  import rr_grant_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               any
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [NUM_REQ-1:0]   sel_rot;
  logic [2*NUM_REQ-1:0] sel_dbl;
  logic [IDX_W-1:0]     sel_idx;
  logic [IDX_W:0]       back_base;

  assign any     = |req;
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: NUM_REQ];

  always_comb begin
    sel_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) sel_idx = IDX_W'(i);
    end
  end

  assign sel_rot = any ? (NUM_REQ'(1) << sel_idx) : '0;

  // Rotating left by ptr is the same as selecting a window starting at NUM_REQ-ptr.
  assign sel_dbl   = {sel_rot, sel_rot};
  assign back_base = (IDX_W + 1)'(NUM_REQ) - {1'b0, ptr};
  assign pick      = sel_dbl[back_base +: NUM_REQ];
  assign pick_idx  = any ? (sel_idx + ptr) : '0;

endmodule

// File: rtl/rr_grant_arbiter16.sv
// Round-robin arbiter for 16 requesters: one-cycle req-to-grant, grant held until done or req drop.
// Optional hold watchdog under RR_GRANT_WATCHDOG_EN forces release after MAX_HOLD cycles.
module rr_grant_arbiter16
    import rr_grant_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid,
    output logic               timeout
);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic               valid_nxt;
    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;
    logic               any;
    logic               release_now;
    logic               force_off;

    rr_pick16 u_pick (
        .req      (req),
        .ptr      (ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (any)
    );

    // Owner releases by strobing done or by dropping its own request.
    assign release_now = done || !req[grant_idx];

`ifdef RR_GRANT_WATCHDOG_EN
    logic [7:0] hold_cnt;
    logic [7:0] hold_cnt_nxt;

    assign force_off    = (state == GRANT) && !release_now && (hold_cnt == 8'(MAX_HOLD - 1));
    assign hold_cnt_nxt = (state == GRANT) ? (hold_cnt + 8'd1) : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= 8'd0;
            timeout  <= 1'b0;
        end else begin
            hold_cnt <= hold_cnt_nxt;
            timeout  <= force_off;
        end
    end
`else
    assign force_off = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && any)            state_nxt = GRANT;
            GRANT:   if (release_now || force_off) state_nxt = IDLE;
            default:                               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_nxt = grant;
        idx_nxt   = grant_idx;
        valid_nxt = grant_valid;
        ptr_nxt   = ptr;
        if (state == IDLE) begin
            if (enable && any) begin
                grant_nxt = pick;
                idx_nxt   = pick_idx;
                valid_nxt = 1'b1;
            end
        end else if (release_now || force_off) begin
            grant_nxt = '0;
            idx_nxt   = '0;
            valid_nxt = 1'b0;
            ptr_nxt   = grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            ptr         <= '0;
        end else begin
            grant       <= grant_nxt;
            grant_idx   <= idx_nxt;
            grant_valid <= valid_nxt;
            ptr         <= ptr_nxt;
        end
    end

endmodule
